// File: rtl/line_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// line_buffer_ctrl
//
// Streaming line-buffer controller placed in front of a KER_SIZE-bank row SRAM
// (sram_array_k2/k3/k5). Raster-order pixels arrive over a valid/ready
// handshake. Each image row is written into one SRAM bank, and the banks are
// used in rotation. After KER_SIZE-1 rows have been buffered, every accepted
// pixel also reads the other banks at the same column. One cycle later the
// controller emits a vertical column of KER_SIZE words: the buffered rows plus
// the current pixel.
//
// Ports
//   clk, rst      single clock; synchronous active-high reset
//   start         one-cycle frame start pulse, honoured only while idle
//   in_valid/in_ready/in_data   pixel input handshake
//   sram_a        column address to the SRAM
//   sram_wen      one-hot bank write enable
//   sram_ren      bank read enables (all banks except the one being written)
//   sram_d        SRAM write data
//   sram_q        reordered SRAM read data, newest row in the MSB slice
//   col_valid     column strobe (no backpressure)
//   col_data      {current pixel, newest buffered row, ..., oldest row}
//   col_x         column index of col_data
//   col_row       index of the oldest (top) row in col_data
//   busy          a frame is in progress
//   done          pulse that coincides with the final column of a frame
// -----------------------------------------------------------------------------
module line_buffer_ctrl #(
  parameter int KER_SIZE = 3,
  parameter int DW       = 32,
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int AW       = $clog2(IMG_W)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DW-1:0]                in_data,
  output logic [AW-1:0]                sram_a,
  output logic [KER_SIZE-1:0]          sram_wen,
  output logic [KER_SIZE-1:0]          sram_ren,
  output logic [DW-1:0]                sram_d,
  input  logic [(KER_SIZE-1)*DW-1:0]   sram_q,
  output logic                         col_valid,
  output logic [KER_SIZE*DW-1:0]       col_data,
  output logic [AW-1:0]                col_x,
  output logic [$clog2(IMG_H)-1:0]     col_row,
  output logic                         busy,
  output logic                         done
);

  localparam int YW = $clog2(IMG_H);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [AW-1:0]       x;
  logic [YW-1:0]       y;
  logic [KER_SIZE-1:0] wr_row;
  logic [AW-1:0]       a_hold;
  logic [DW-1:0]       d_hold;
  logic [DW-1:0]       pix_dly;

  logic xfer;
  logic row_end;
  logic last_px;
  logic fill_end;

  assign in_ready = (state == ST_FILL) || (state == ST_STREAM);
  assign busy     = (state != ST_IDLE);
  assign xfer     = in_valid && in_ready;
  assign row_end  = (x == AW'(IMG_W - 1));
  assign last_px  = row_end && (y == YW'(IMG_H - 1));
  // The last FILL row is y = KER_SIZE-2; its final pixel hands over to STREAM.
  assign fill_end = row_end && (y == YW'(KER_SIZE - 2));

  // SRAM drive: address/data pass through on a transfer and otherwise hold
  // their previous value; the enables are only active on a transfer.
  always_comb begin
    sram_wen = '0;
    sram_ren = '0;
    sram_a   = a_hold;
    sram_d   = d_hold;
    if (xfer) begin
      sram_a   = x;
      sram_d   = in_data;
      sram_wen = wr_row;
      if (state == ST_STREAM) begin
        sram_ren = ~wr_row;
      end else begin
        sram_ren = '0;
      end
    end else begin
      sram_wen = '0;
      sram_ren = '0;
    end
  end

  // The SRAM read data arrives one cycle after the transfer, aligned with the
  // delayed pixel. The column is forced to zero when not valid, so its value
  // does not depend on what the idle SRAM outputs.
  always_comb begin
    if (col_valid) begin
      col_data = {pix_dly, sram_q};
    end else begin
      col_data = '0;
    end
  end

  // Frame sequencing: IDLE -> FILL -> STREAM -> DRAIN -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_FILL;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (xfer && fill_end) begin
          state_nxt = ST_STREAM;
        end else begin
          state_nxt = ST_FILL;
        end
      end
      ST_STREAM: begin
        if (xfer && last_px) begin
          state_nxt = ST_DRAIN;
        end else begin
          state_nxt = ST_STREAM;
        end
      end
      ST_DRAIN: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register plus the column/row counters and the bank pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      x      <= '0;
      y      <= '0;
      wr_row <= KER_SIZE'(1);
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && start) begin
        x      <= '0;
        y      <= '0;
        wr_row <= KER_SIZE'(1);
      end else if (xfer) begin
        if (row_end) begin
          x      <= '0;
          // Clamp y back to 0 after the last row instead of letting it wrap.
          y      <= last_px ? '0 : (y + YW'(1));
          wr_row <= {wr_row[KER_SIZE-2:0], wr_row[KER_SIZE-1]};
        end else begin
          x <= x + AW'(1);
        end
      end else begin
        x      <= x;
        y      <= y;
        wr_row <= wr_row;
      end
    end
  end

  // Hold registers for the SRAM address/data, the pixel delay line and the
  // registered column side-band outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_hold    <= '0;
      d_hold    <= '0;
      pix_dly   <= '0;
      col_valid <= 1'b0;
      col_x     <= '0;
      col_row   <= '0;
      done      <= 1'b0;
    end else begin
      col_valid <= xfer && (state == ST_STREAM);
      done      <= xfer && (state == ST_STREAM) && last_px;
      if (xfer) begin
        a_hold  <= x;
        d_hold  <= in_data;
        pix_dly <= in_data;
      end else begin
        a_hold  <= a_hold;
        d_hold  <= d_hold;
        pix_dly <= pix_dly;
      end
      if (xfer && (state == ST_STREAM)) begin
        col_x   <= x;
        col_row <= y - YW'(KER_SIZE - 1);
      end else begin
        col_x   <= col_x;
        col_row <= col_row;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_line_buffer_ctrl
//
// Directed bench for line_buffer_ctrl with KER_SIZE=3, IMG_W=4, IMG_H=4 and
// pixel value 16*y + x. A small behavioural SRAM (three banks, one-cycle read,
// newest row in the MSB slice) closes the loop around the controller.
// -----------------------------------------------------------------------------
module tb_line_buffer_ctrl;

  localparam int K    = 3;
  localparam int DW   = 32;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int AW   = 2;
  localparam int YW   = 2;
  localparam int NPIX = W * H;
  localparam int NCOL = (H - K + 1) * W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_data;
  logic [AW-1:0]        sram_a;
  logic [K-1:0]         sram_wen;
  logic [K-1:0]         sram_ren;
  logic [DW-1:0]        sram_d;
  logic [(K-1)*DW-1:0]  sram_q;
  logic                 col_valid;
  logic [K*DW-1:0]      col_data;
  logic [AW-1:0]        col_x;
  logic [YW-1:0]        col_row;
  logic                 busy;
  logic                 done;

  int n_assert = 0;
  int n_fail   = 0;

  line_buffer_ctrl #(.KER_SIZE(K), .DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sram_a(sram_a), .sram_wen(sram_wen), .sram_ren(sram_ren),
    .sram_d(sram_d), .sram_q(sram_q),
    .col_valid(col_valid), .col_data(col_data), .col_x(col_x),
    .col_row(col_row), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural row SRAM: bank b is read unless it is the one being written.
  logic [DW-1:0] mem [K][W];

  function automatic int zero_idx(input logic [K-1:0] r);
    for (int i = 0; i < K; i++) begin
      if (!r[i]) return i;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    for (int b = 0; b < K; b++) begin
      if (sram_wen[b]) mem[b][sram_a] <= sram_d;
    end
    if (sram_ren != '0) begin
      // Slice 0 = oldest (bank after the write bank), top slice = newest.
      for (int j = 0; j < K - 1; j++) begin
        sram_q[j*DW +: DW] <= mem[(zero_idx(sram_ren) + 1 + j) % K][sram_a];
      end
    end else begin
      sram_q <= '0;
    end
  end

  function automatic logic [DW-1:0] px(input int yy, input int xx);
    return DW'(16 * yy + xx);
  endfunction

  function automatic logic [K*DW-1:0] exp_col(input int i);
    int r;
    int xx;
    r  = i / W;
    xx = i % W;
    return {px(r + 2, xx), px(r + 1, xx), px(r, xx)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".in_ready"},  128'(in_ready),  128'(0));
    chk({tag, ".col_valid"}, 128'(col_valid), 128'(0));
    chk({tag, ".done"},      128'(done),      128'(0));
    chk({tag, ".busy"},      128'(busy),      128'(0));
    chk({tag, ".col_data"},  128'(col_data),  128'(0));
    chk({tag, ".col_x"},     128'(col_x),     128'(0));
    chk({tag, ".col_row"},   128'(col_row),   128'(0));
    chk({tag, ".sram_wen"},  128'(sram_wen),  128'(0));
    chk({tag, ".sram_ren"},  128'(sram_ren),  128'(0));
  endtask

  // One full frame. bubbles: in_valid alternates 1/0. abuse: start is pulsed
  // during the frame and must be ignored.
  task automatic run_frame(input bit bubbles, input bit abuse);
    int  k    = 0;
    int  idx  = 0;
    int  ncol = 0;
    int  cyc  = 0;
    bit  drv;
    bit  nxt;
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("start.busy",     128'(busy),      128'(1));
    chk("start.in_ready", 128'(in_ready),  128'(1));
    while (k < NPIX && cyc < 200) begin
      drv = !bubbles || (cyc % 2 == 0);
      nxt = 1'b0;
      if (drv) begin
        in_valid = 1'b1;
        in_data  = px(k / W, k % W);
        if (abuse && (k == 6 || k == 10)) start = 1'b1;
        #1;
        chk("in_ready", 128'(in_ready), 128'(1));
        if (k == 0) begin
          chk("fill.wen", 128'(sram_wen), 128'(3'b001));
          chk("fill.ren", 128'(sram_ren), 128'(3'b000));
        end
        if (k == 12) begin
          chk("rot.wen", 128'(sram_wen), 128'(3'b001));
          chk("rot.ren", 128'(sram_ren), 128'(3'b110));
          chk("rot.a",   128'(sram_a),   128'(0));
          chk("rot.d",   128'(sram_d),   128'(32'h30));
        end
        nxt = (k >= (K - 1) * W);
        k++;
      end else begin
        in_valid = 1'b0;
        in_data  = $urandom;
        #1;
        chk("bubble.wen", 128'(sram_wen), 128'(0));
      end
      @(negedge clk);
      start = 1'b0;
      ncol += int'(col_valid);
      chk("col_valid", 128'(col_valid), 128'(nxt));
      if (nxt) begin
        chk("col_data", 128'(col_data), 128'(exp_col(idx)));
        chk("col_x",    128'(col_x),    128'(idx % W));
        chk("col_row",  128'(col_row),  128'(idx / W));
        chk("done",     128'(done),     128'(idx == NCOL - 1));
        idx++;
      end else begin
        chk("done", 128'(done), 128'(0));
      end
      cyc++;
    end
    chk("frame.timeout", 128'(cyc < 200), 128'(1));
    // in_valid is still high here: the DRAIN cycle must not accept it.
    chk("drain.in_ready", 128'(in_ready), 128'(0));
    chk("drain.busy",     128'(busy),     128'(1));
    in_valid = 1'b0;
    @(negedge clk);
    chk("end.busy",      128'(busy),      128'(0));
    chk("end.col_valid", 128'(col_valid), 128'(0));
    chk("end.done",      128'(done),      128'(0));
    chk("col_count",     128'(ncol),      128'(NCOL));
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");

    // in_valid held while idle: nothing may be accepted.
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("pre.in_ready", 128'(in_ready), 128'(0));
      chk("pre.wen",      128'(sram_wen), 128'(0));
      chk("pre.busy",     128'(busy),     128'(0));
    end
    in_valid = 1'b0;

    run_frame(1'b0, 1'b0);
    run_frame(1'b1, 1'b0);
    run_frame(1'b0, 1'b1);

    // Reset mid-frame at y=2, x=1, then a clean frame must follow.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1;
      in_data  = px(k / W, k % W);
      @(negedge clk);
    end
    in_data = px(2, 1);
    rst     = 1'b1;
    @(negedge clk);
    chk_idle_outputs("midrst");
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst.busy",      128'(busy),      128'(0));
    chk("midrst.col_valid", 128'(col_valid), 128'(0));
    run_frame(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Streaming line-buffer controller that sits directly upstream of `sram_array_k3` / `_k5` / `_k2` and drives their address, enables and write data. It accepts a raster-order pixel stream over a valid/ready handshake and writes each image row into one SRAM row bank in rotation. Once KER_SIZE-1 rows are buffered, it reads the other banks at the same column address. Each cycle it emits one vertical column of KER_SIZE words to the downstream window/MAC stage: the buffered rows from the SRAM plus the current pixel.

## Interface
- KER_SIZE, 3: number of row banks and column height; legal values 2, 3, 5.
- DW, 32: pixel word width.
- IMG_W, 32: pixels per row; must be ≤ the SRAM NW.
- IMG_H, 32: rows per frame; must be ≥ KER_SIZE.
- AW, $clog2(IMG_W): column address width; must match the SRAM AW.
- clk  in  1  clock, single domain.
- rst  in  1  synchronous reset, active-high. The SRAM array's `rstn` is tied to `~rst` at the parent.
- start  in  1  one-cycle pulse that begins a frame; ignored unless idle.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  controller can accept a pixel.
- in_data  in  DW  input pixel.
- sram_a  out  AW  column address, to SRAM `a`.
- sram_wen  out  KER_SIZE  one-hot bank write enable, to SRAM `wen`.
- sram_ren  out  KER_SIZE  bank read enables, to SRAM `ren`.
- sram_d  out  DW  write data, to SRAM `d`.
- sram_q  in  (KER_SIZE-1)*DW  reordered read data from the SRAM; MSB slice is the newest row.
- col_valid  out  1  col_data is valid; downstream must accept it (no backpressure).
- col_data  out  KER_SIZE*DW  column; MSB slice is the current-row pixel, LSB slice is the oldest row.
- col_x  out  AW  column index of col_data.
- col_row  out  $clog2(IMG_H)  index of the oldest (top) row in col_data.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse coinciding with the final col_valid.

## Operation
- States: IDLE, FILL, STREAM, DRAIN.
  - IDLE: on `start`, clear x, y and wr_row, then go to FILL.
  - FILL: while y < KER_SIZE-1; moves to STREAM when y reaches KER_SIZE-1.
  - STREAM: runs until the last pixel is accepted, then goes to DRAIN.
  - DRAIN: lasts one cycle, then returns to IDLE.
- `in_ready` = 1 in FILL and STREAM only. A transfer occurs when in_valid & in_ready.
- Registered counters, all reset to 0:
  - `x` (0..IMG_W-1), column counter.
  - `y` (0..IMG_H-1), row counter.
  - `wr_row`, a one-hot bank pointer that resets to bit 0.
- Combinational SRAM drive:
  - On a transfer: sram_a = x, sram_d = in_data, sram_wen = wr_row.
  - sram_ren = ~wr_row in STREAM, 0 in FILL.
  - With no transfer: wen = ren = 0 and sram_a/sram_d hold their last value (don't-care).
- Per transfer:
  - x increments.
  - At x = IMG_W-1: x wraps to 0, y increments, and wr_row rotates left (bit KER_SIZE-1 wraps to bit 0).
- Column output: every STREAM transfer produces exactly one col_valid one cycle later.
  - col_data = {in_data registered at the transfer, sram_q}.
  - col_x = registered x.
  - col_row = registered y − (KER_SIZE-1).
- Columns per frame: (IMG_H − KER_SIZE + 1) × IMG_W. No column is emitted for FILL transfers.
- Frame end: the last transfer is at x = IMG_W-1, y = IMG_H-1. The next cycle is DRAIN, which emits the final col_valid together with done = 1.
- `start` outside IDLE is ignored. `in_valid` in IDLE/DRAIN is not accepted.
- Reset mid-frame: everything returns to the reset state. The next `start` begins a fresh frame with no stale columns; bank contents need no clearing because FILL overwrites them.

## Timing
- Reset values:
  - in_ready, col_valid, done, busy = 0.
  - col_data, col_x, col_row = 0.
  - sram_wen = sram_ren = 0.
  - x = y = 0, wr_row = 1.
- `start` at cycle S: busy = 1 and in_ready = 1 from S+1.
- Transfer at cycle T (STREAM): col_valid at T+1, matching the 1-cycle SRAM read latency.
- The in_data delay register and the SRAM read are aligned so that all slices of col_data belong to the same x.
- Bubbles: a cycle without a transfer yields col_valid = 0 one cycle later. The SRAM enables are low, so the array's q goes to 0; it is not used.
- busy falls the cycle after DRAIN. A new start is accepted that cycle at the earliest.
- Throughput: 1 pixel per cycle sustained. Row changes and the FILL→STREAM change insert no bubbles.

## Test plan
Common setup: KER_SIZE=3, IMG_W=4, IMG_H=4, pixel value = 16·y + x.

- Reset: assert rst for 2 cycles with in_valid = 1 → all outputs at their reset values; in_ready = 0.
- Continuous frame: start, then 16 back-to-back pixels →
  - first col_valid one cycle after the 9th transfer, with col_data = {0x20,0x10,0x00}, col_x = 0, col_row = 0;
  - exactly 8 columns in total;
  - last column {0x33,0x23,0x13} with done = 1 in the same cycle; busy = 0 the next cycle.
- Bank rotation: during the y = 3, x = 0 transfer → sram_wen = 3'b001 and sram_ren = 3'b110; the next col_data = {0x30,0x20,0x10} with col_row = 1.
- Bubbles: in_valid alternates 1/0 for the whole frame → the same 8 columns in the same order; col_valid = 0 one cycle after each idle cycle.
- Control abuse:
  - start pulsed mid-frame → no effect.
  - in_valid held before start → no transfer; in_ready = 0.
- Reset mid-frame: assert rst at y = 2, x = 1, then restart a frame → output identical to the continuous-frame scenario.
